// File: rtl/memory_read_responder_pkg.sv
// Shared types for the instruction-memory read responder: FSM state encoding
// and the sizing helper for the read-latency counter.
package memory_read_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } responder_state_t;

    // The counter is loaded with READ_LATENCY-1, so it needs clog2(READ_LATENCY) bits, minimum one.
    function automatic int latency_cnt_width(input int read_latency);
        return (read_latency > 1) ? $clog2(read_latency) : 1;
    endfunction

endpackage

// File: rtl/memory_read_iface.sv
// Read request/response bundle between the mesh arbiter (requester) and the
// instruction memory responder.
interface memory_read_iface #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 20
);

    logic [ADDR_WIDTH-1:0] addr;
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;

    modport in (
        input  addr,
        input  valid,
        output ready,
        output data
    );

    modport out (
        output addr,
        output valid,
        input  ready,
        input  data
    );

endinterface

// File: rtl/sync_ram_rf.sv
// Single-clock RAM with one write and one read port, read-first ordering and
// an optional output register (READ_LATENCY = 2).
module sync_ram_rf #(
    parameter int WIDTH        = 20,
    parameter int DEPTH        = 2048,
    parameter int IDX_WIDTH    = 11,
    parameter int READ_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [IDX_WIDTH-1:0] wr_idx,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic                 rd_en,
    input  logic [IDX_WIDTH-1:0] rd_idx,
    output logic [WIDTH-1:0]     rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_q;

    // Non-blocking ordering makes a same-cycle read return the pre-write word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
        if (rd_en) begin
            rd_q <= mem[rd_idx];
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_out_reg
            logic [WIDTH-1:0] rd_q2;
            always_ff @(posedge clk) begin
                rd_q2 <= rd_q;
            end
            assign rd_data = rd_q2;
        end else begin : g_direct
            assign rd_data = rd_q;
        end
    endgenerate

endmodule

// File: rtl/memory_read_responder.sv
// Serving end of memory_read_iface: accepts one arbitrated read at a time,
// owns the instruction RAM and returns data with a one-cycle ready pulse.
module memory_read_responder
    import memory_read_responder_pkg::*;
#(
    parameter int MEMORY_WIDTH      = 20,
    parameter int MEMORY_ADDR_WIDTH = 11,
    parameter int MEMORY_DEPTH      = 2048,
    parameter int READ_LATENCY      = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    memory_read_iface.in                 memory,
    input  logic                         wr_en,
    input  logic [MEMORY_ADDR_WIDTH-1:0] wr_addr,
    input  logic [MEMORY_WIDTH-1:0]      wr_data,
    output logic                         busy,
    output logic                         oob
);

    localparam int IDX_WIDTH = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
    localparam int CNT_WIDTH = latency_cnt_width(READ_LATENCY);
    localparam logic [CNT_WIDTH-1:0] CNT_INIT = CNT_WIDTH'(READ_LATENCY - 1);
    localparam logic [MEMORY_ADDR_WIDTH:0] DEPTH_LIMIT = MEMORY_DEPTH[MEMORY_ADDR_WIDTH:0];

    responder_state_t               state;
    logic [CNT_WIDTH-1:0]           lat_cnt;
    logic [MEMORY_ADDR_WIDTH-1:0]   cap_addr;
    logic                           ready_q;
    logic [MEMORY_WIDTH-1:0]        data_q;
    logic                           oob_q;

    logic                           accept;
    logic                           wr_in_bounds;
    logic                           cap_in_bounds;
    logic [MEMORY_WIDTH-1:0]        ram_rd_data;

    // A host write in the same cycle wins; the requester simply retries.
    assign accept        = (state == IDLE) && memory.valid && !wr_en;
    assign wr_in_bounds  = {1'b0, wr_addr} < DEPTH_LIMIT;
    assign cap_in_bounds = {1'b0, cap_addr} < DEPTH_LIMIT;

    sync_ram_rf #(
        .WIDTH        (MEMORY_WIDTH),
        .DEPTH        (MEMORY_DEPTH),
        .IDX_WIDTH    (IDX_WIDTH),
        .READ_LATENCY (READ_LATENCY)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en && wr_in_bounds),
        .wr_idx  (wr_addr[IDX_WIDTH-1:0]),
        .wr_data (wr_data),
        .rd_en   (accept),
        .rd_idx  (memory.addr[IDX_WIDTH-1:0]),
        .rd_data (ram_rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            lat_cnt  <= '0;
            cap_addr <= '0;
            ready_q  <= 1'b0;
            data_q   <= '0;
            oob_q    <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            oob_q   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        cap_addr <= memory.addr;
                        lat_cnt  <= CNT_INIT;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    // RAM output is valid in the last WAIT cycle; latch it as the response.
                    if (lat_cnt == '0) begin
                        state   <= RESP;
                        ready_q <= 1'b1;
                        oob_q   <= !cap_in_bounds;
                        data_q  <= cap_in_bounds ? ram_rd_data : '0;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign memory.ready = ready_q;
    assign memory.data  = data_q;
    assign oob          = oob_q;
    assign busy         = (state != IDLE);

endmodule

// File: tb/tb_memory_read_responder.sv
// Directed bench for memory_read_responder: runs the same scenarios against a
// READ_LATENCY=1 and a READ_LATENCY=2 instance, both with MEMORY_DEPTH=1024.
module tb_memory_read_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic [10:0] addr = '0;
    logic        wr_en = 1'b0;
    logic [10:0] wr_addr = '0;
    logic [19:0] wr_data = '0;
    logic        cur = 1'b0;
    int          lat = 1;

    int compared = 0;
    int mismatched = 0;

    logic        busy1, busy2, oob1, oob2;
    logic        obs_ready, obs_busy, obs_oob;
    logic [19:0] obs_data;

    memory_read_iface #(.ADDR_WIDTH(11), .DATA_WIDTH(20)) m1 ();
    memory_read_iface #(.ADDR_WIDTH(11), .DATA_WIDTH(20)) m2 ();

    assign m1.addr  = addr;
    assign m2.addr  = addr;
    assign m1.valid = valid && !cur;
    assign m2.valid = valid && cur;

    memory_read_responder #(
        .MEMORY_WIDTH(20), .MEMORY_ADDR_WIDTH(11), .MEMORY_DEPTH(1024), .READ_LATENCY(1)
    ) dut1 (
        .clk(clk), .rst(rst), .memory(m1), .wr_en(wr_en && !cur), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy1), .oob(oob1)
    );

    memory_read_responder #(
        .MEMORY_WIDTH(20), .MEMORY_ADDR_WIDTH(11), .MEMORY_DEPTH(1024), .READ_LATENCY(2)
    ) dut2 (
        .clk(clk), .rst(rst), .memory(m2), .wr_en(wr_en && cur), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy2), .oob(oob2)
    );

    assign obs_ready = cur ? m2.ready : m1.ready;
    assign obs_data  = cur ? m2.data  : m1.data;
    assign obs_busy  = cur ? busy2    : busy1;
    assign obs_oob   = cur ? oob2     : oob1;

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [10:0] a, input logic [19:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic test_read_transaction(input logic [10:0] a, input logic [19:0] exp_d,
                                         input logic exp_oob, input string name);
        valid = 1'b1; addr = a;
        for (int k = 0; k < lat; k++) begin
            step();
            compared++;
            if (obs_ready !== 1'b0 || obs_busy !== 1'b1) begin
                mismatched++;
                $display("[TB] FAIL %s wait: ready=%b busy=%b expected ready=0 busy=1", name, obs_ready, obs_busy);
            end
        end
        step();
        compared++;
        if (obs_ready !== 1'b1 || obs_data !== exp_d || obs_oob !== exp_oob || obs_busy !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL %s resp: ready=%b data=%h oob=%b busy=%b expected 1/%h/%b/1",
                     name, obs_ready, obs_data, obs_oob, obs_busy, exp_d, exp_oob);
        end
        valid = 1'b0;
        step();
        compared++;
        if (obs_ready !== 1'b0 || obs_busy !== 1'b0 || obs_oob !== 1'b0 || obs_data !== exp_d) begin
            mismatched++;
            $display("[TB] FAIL %s hold: ready=%b busy=%b oob=%b data=%h expected 0/0/0/%h",
                     name, obs_ready, obs_busy, obs_oob, obs_data, exp_d);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; valid = 1'b0; wr_en = 1'b0;
        step();
        step();
        compared++;
        if (obs_ready !== 1'b0 || obs_data !== 20'h0 || obs_busy !== 1'b0 || obs_oob !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset: ready=%b data=%h busy=%b oob=%b expected all 0",
                     obs_ready, obs_data, obs_busy, obs_oob);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic preload();
        host_write(11'd5,    20'h0ABCD);
        host_write(11'd6,    20'h00123);
        host_write(11'd7,    20'h00007);
        host_write(11'd9,    20'h00009);
        host_write(11'd476,  20'h0476A);
        host_write(11'd1023, 20'h3FFFF);
    endtask

    task automatic test_basic_read();
        test_read_transaction(11'd5, 20'h0ABCD, 1'b0, "basic_addr5");
    endtask

    task automatic test_back_to_back();
        valid = 1'b1; addr = 11'd5;
        for (int k = 0; k < lat; k++) step();
        step();
        compared++;
        if (obs_ready !== 1'b1 || obs_data !== 20'h0ABCD) begin
            mismatched++;
            $display("[TB] FAIL b2b_first: ready=%b data=%h expected 1/0abcd", obs_ready, obs_data);
        end
        addr = 11'd6;
        for (int k = 0; k < lat + 1; k++) begin
            step();
            compared++;
            if (obs_ready !== 1'b0 || obs_data !== 20'h0ABCD) begin
                mismatched++;
                $display("[TB] FAIL b2b_gap: ready=%b data=%h expected 0/0abcd", obs_ready, obs_data);
            end
        end
        step();
        compared++;
        if (obs_ready !== 1'b1 || obs_data !== 20'h00123) begin
            mismatched++;
            $display("[TB] FAIL b2b_second: ready=%b data=%h expected 1/00123", obs_ready, obs_data);
        end
        valid = 1'b0;
        step();
        compared++;
        if (obs_ready !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL b2b_no_dup: ready=%b expected 0", obs_ready);
        end
    endtask

    task automatic test_write_collision();
        valid = 1'b1; addr = 11'd7;
        wr_en = 1'b1; wr_addr = 11'd7; wr_data = 20'h11111;
        step();
        wr_en = 1'b0;
        compared++;
        if (obs_busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL collision_defer: busy=%b expected 0", obs_busy);
        end
        for (int k = 0; k < lat; k++) begin
            step();
            compared++;
            if (obs_ready !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL collision_wait: ready=%b expected 0", obs_ready);
            end
        end
        step();
        compared++;
        if (obs_ready !== 1'b1 || obs_data !== 20'h11111) begin
            mismatched++;
            $display("[TB] FAIL collision_resp: ready=%b data=%h expected 1/11111", obs_ready, obs_data);
        end
        valid = 1'b0;
        step();
    endtask

    task automatic test_read_first();
        valid = 1'b1; addr = 11'd9;
        step();
        wr_en = 1'b1; wr_addr = 11'd9; wr_data = 20'h22222;
        step();
        wr_en = 1'b0;
        for (int k = 1; k < lat; k++) begin
            compared++;
            if (obs_ready !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL read_first_wait: ready=%b expected 0", obs_ready);
            end
            step();
        end
        compared++;
        if (obs_ready !== 1'b1 || obs_data !== 20'h00009) begin
            mismatched++;
            $display("[TB] FAIL read_first_resp: ready=%b data=%h expected 1/00009", obs_ready, obs_data);
        end
        valid = 1'b0;
        step();
        test_read_transaction(11'd9, 20'h22222, 1'b0, "read_first_after");
    endtask

    task automatic test_out_of_bounds();
        test_read_transaction(11'd1500, 20'h0, 1'b1, "oob_1500");
        host_write(11'd1500, 20'h33333);
        test_read_transaction(11'd476, 20'h0476A, 1'b0, "oob_write_dropped");
        test_read_transaction(11'd1023, 20'h3FFFF, 1'b0, "bound_1023");
        test_read_transaction(11'd1024, 20'h0, 1'b1, "oob_1024");
    endtask

    task automatic test_reset_mid_wait();
        test_read_transaction(11'd5, 20'h0ABCD, 1'b0, "pre_reset_read");
        valid = 1'b1; addr = 11'd5;
        step();
        compared++;
        if (obs_busy !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL rst_wait_busy: busy=%b expected 1", obs_busy);
        end
        rst = 1'b1; valid = 1'b0;
        #1;
        compared++;
        if (obs_ready !== 1'b0 || obs_busy !== 1'b0 || obs_data !== 20'h0) begin
            mismatched++;
            $display("[TB] FAIL rst_immediate: ready=%b busy=%b data=%h expected 0/0/0",
                     obs_ready, obs_busy, obs_data);
        end
        step();
        rst = 1'b0;
        for (int k = 0; k < lat + 3; k++) begin
            step();
            compared++;
            if (obs_ready !== 1'b0 || obs_busy !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL rst_no_pulse: ready=%b busy=%b expected 0/0", obs_ready, obs_busy);
            end
        end
        test_read_transaction(11'd6, 20'h00123, 1'b0, "post_reset_read");
    endtask

    task automatic run_suite(input logic sel);
        cur = sel;
        lat = sel ? 2 : 1;
        $display("[TB] running READ_LATENCY=%0d instance", lat);
        test_reset();
        preload();
        test_basic_read();
        test_back_to_back();
        test_write_collision();
        test_read_first();
        test_out_of_bounds();
        test_reset_mid_wait();
    endtask

    initial begin
        run_suite(1'b0);
        run_suite(1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/memory_read_responder.md
Name: memory_read_responder

Overview:
- Serving end of memory_read_iface: receives one arbitrated read request (addr/valid) and returns instruction data with a one-cycle ready pulse.
- Sits directly below the mesh-level round-robin memory arbiter; owns the instruction RAM.
- Has a host write port used to load the program before or between runs.

Parameters:
- MEMORY_WIDTH, 20, data word width.
- MEMORY_ADDR_WIDTH, 11, address width.
- MEMORY_DEPTH, 2048, implemented words; must be ≤ 2**MEMORY_ADDR_WIDTH.
- READ_LATENCY, 1, RAM read latency in cycles (1 or 2; 2 adds an output register).

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- memory  memory_read_iface.in  -  request side, with these members:
  - memory.addr  input  MEMORY_ADDR_WIDTH  read address.
  - memory.valid  input  1  request pending.
  - memory.ready  output  1  one-cycle pulse: response is in memory.data.
  - memory.data  output  MEMORY_WIDTH  read data, broadcast to all requesters.
- wr_en  input  1  host write strobe.
- wr_addr  input  MEMORY_ADDR_WIDTH  host write address.
- wr_data  input  MEMORY_WIDTH  host write data.
- busy  output  1  a request is in flight (state != IDLE).
- oob  output  1  one-cycle pulse with ready when the address served was ≥ MEMORY_DEPTH.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; ready=0, data=0, busy=0, oob=0; latency counter=0, captured addr=0.
  - RAM contents are not reset.
- Requester rule: holds addr and valid stable until it sees ready. After ready it may present a new address in the next cycle.
- FSM IDLE:
  - valid=1 and wr_en=0: capture addr, issue RAM read, counter=READ_LATENCY-1, go WAIT.
  - valid=1 and wr_en=1: write takes priority; the request is not accepted and is retried next cycle.
- FSM WAIT:
  - Counter decrements; when it reaches 0, go RESP.
  - READ_LATENCY=1 therefore spends exactly one cycle in WAIT.
- FSM RESP:
  - ready=1 for this cycle only; data = RAM output, or 0 if the address is out of bounds; oob set accordingly.
  - valid is ignored in this cycle (it is the request already being served). Next state is IDLE.
- Latency: request accepted in cycle t gives ready in cycle t+READ_LATENCY+1. Throughput is one response per READ_LATENCY+2 cycles.
- memory.data holds the last response value until the next RESP; it never changes outside RESP.
- Writes:
  - Executed in any state the cycle wr_en=1; wr_addr ≥ MEMORY_DEPTH is silently dropped.
  - The RAM is read-first. A write to the pending address after the read was issued does not change the returned data.
  - A write that blocks acceptance in IDLE is visible to the following read.
- valid deasserted in WAIT is a protocol violation; the response is still produced and the state returns to IDLE.
- Reset asserted mid-WAIT or mid-RESP: immediate return to IDLE with ready=0. Data is cleared to 0 and no response is emitted.
- Address arithmetic: bounds check is an unsigned compare addr < MEMORY_DEPTH; the RAM index uses the low $clog2(MEMORY_DEPTH) bits.

Decomposition:
- Shared coprocessor package: responder state enum (IDLE, WAIT, RESP) and a function returning the latency-counter width from READ_LATENCY.
- One sub-module: sync_ram_rf (single clock, one write port, one read port, read-first, optional output register selected by READ_LATENCY).
- The FSM, bounds check and response register stay in memory_read_responder.

Test Plan:
- Preload addr 5 = 0x0ABCD; then valid=1, addr=5 at cycle 10, READ_LATENCY=1 → ready=1 only in cycle 12, data=0x0ABCD, oob=0; busy high in cycles 11-12.
- Back-to-back requests addr 5 then addr 6 (=0x00123), valid held continuously → two ready pulses 3 cycles apart. Data is 0x0ABCD then 0x00123; no duplicate response for addr 5.
- Same cycle: valid=1 addr=7 and wr_en=1 wr_addr=7 wr_data=0x11111 → request deferred one cycle; the response returns 0x11111.
- After acceptance of addr 9 (old 0x00009), write 0x22222 to addr 9 during WAIT → the response returns 0x00009.
- MEMORY_DEPTH=1024, request addr 1500 → ready pulse with data=0 and oob=1. Write to 1500 is dropped; RAM is unchanged.
- Assert rst during WAIT → ready, busy and data are 0 immediately; no ready pulse follows. A fresh request afterward completes normally; repeat the scenarios with READ_LATENCY=2 (ready at t+3).
